// File: rtl/mips_dmem_responder.sv
// rtl/mips_dmem_responder.sv - word data-memory responder with wait states and debug read port
module mips_dmem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  input  logic [31:0] dbg_addr,
  output logic [31:0] dbg_rdata
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);
  localparam logic [3:0]  WLAST   = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        state, state_nx;
  logic [3:0]    cnt, cnt_nx;
  logic          lat_we;
  logic [31:0]   lat_addr, lat_wdata;
  logic          accept, enter_resp;
  logic          cur_we, cur_err;
  logic [31:0]   cur_addr, cur_wdata;
  logic [AW-1:0] cur_idx;
  logic [31:0]   mem [DEPTH];

  // Gating with rst_n keeps ready low while reset is held even though state is IDLE.
  assign req_ready = rst_n & (state == S_IDLE);
  assign accept    = req_valid & req_ready;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      S_IDLE: begin
        if (accept) begin
          cnt_nx   = 4'd0;
          state_nx = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt == WLAST) state_nx = S_RESP;
        else              cnt_nx   = cnt + 4'd1;
      end
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // With zero wait states RESP is entered on the accept edge, before anything is latched.
  always_comb begin
    enter_resp = (state_nx == S_RESP);
    cur_we     = (state == S_IDLE) ? req_we    : lat_we;
    cur_addr   = (state == S_IDLE) ? req_addr  : lat_addr;
    cur_wdata  = (state == S_IDLE) ? req_wdata : lat_wdata;
    cur_err    = (cur_addr[1:0] != 2'b00) || (cur_addr[31:2] >= DEPTH_W);
    cur_idx    = cur_addr[AW+1:2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      lat_we     <= 1'b0;
      lat_addr   <= 32'd0;
      lat_wdata  <= 32'd0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
      end
      resp_valid <= enter_resp;
      resp_err   <= enter_resp & cur_err;
      resp_rdata <= (enter_resp && !cur_we && !cur_err) ? mem[cur_idx] : 32'd0;
    end
  end

  // Memory has no reset so preloaded contents survive reset pulses.
  always_ff @(posedge clk) begin
    if (enter_resp && cur_we && !cur_err) mem[cur_idx] <= cur_wdata;
  end

  logic unused_dbg_lsb;
  assign unused_dbg_lsb = ^dbg_addr[1:0];
  assign dbg_rdata = (dbg_addr[31:2] < DEPTH_W) ? mem[dbg_addr[AW+1:2]] : 32'd0;

endmodule

// File: tb/tb_mips_dmem_responder.sv
// tb/tb_mips_dmem_responder.sv - randomized self-checking bench for mips_dmem_responder
module tb_mips_dmem_responder;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_w1 = 1'b0, valid_w0 = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0, dbg_addr = 32'd0;
  logic        ready_w1, ready_w0, rv_w1, rv_w0, err_w1, err_w0;
  logic [31:0] rdata_w1, rdata_w0, dbg_w1, dbg_w0;

  int checks = 0;
  int fails  = 0;

  logic [31:0] model [2][DEPTH];
  bit          known [2][DEPTH];

  always #5 clk = ~clk;

  mips_dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(1)) dut_w1 (
    .clk(clk), .rst_n(rst_n), .req_valid(valid_w1), .req_ready(ready_w1),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv_w1), .resp_rdata(rdata_w1), .resp_err(err_w1),
    .dbg_addr(dbg_addr), .dbg_rdata(dbg_w1));

  mips_dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst_n(rst_n), .req_valid(valid_w0), .req_ready(ready_w0),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv_w0), .resp_rdata(rdata_w0), .resp_err(err_w0),
    .dbg_addr(dbg_addr), .dbg_rdata(dbg_w0));

  function automatic bit exp_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:2] >= DEPTH);
  endfunction

  // z selects the zero-wait instance; returns observed response and latency in cycles
  task automatic do_req(input bit z, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
    int n;
    rdata = 32'd0; err = 1'b0; lat = -1;
    @(negedge clk);
    req_we = we; req_addr = addr; req_wdata = wdata;
    if (z) valid_w0 = 1'b1; else valid_w1 = 1'b1;
    n = 0;
    while (!(z ? ready_w0 : ready_w1) && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin
      checks++; fails++;
      $display("FAIL accept_timeout: ready never seen for addr %h", addr);
      valid_w0 = 1'b0; valid_w1 = 1'b0;
      return;
    end
    @(posedge clk); #1;
    valid_w0 = 1'b0; valid_w1 = 1'b0;
    req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    lat = 1;
    @(negedge clk);
    while (!(z ? rv_w0 : rv_w1) && lat < 30) begin @(negedge clk); lat++; end
    if (lat >= 30) begin
      checks++; fails++;
      $display("FAIL resp_timeout: no resp_valid for addr %h", addr);
      lat = -1;
      return;
    end
    rdata = z ? rdata_w0 : rdata_w1;
    err   = z ? err_w0   : err_w1;
    if (we && !exp_err(addr)) begin
      model[z][addr[7:2]] = wdata;
      known[z][addr[7:2]] = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ready_w1 !== 1'b0 || ready_w0 !== 1'b0) begin fails++;
      $display("FAIL reset_ready: got %b/%b want 0/0", ready_w1, ready_w0); end
    checks++; if ({rv_w1, err_w1, rdata_w1} !== 34'd0 || {rv_w0, err_w0, rdata_w0} !== 34'd0) begin fails++;
      $display("FAIL reset_outputs: got %b %b %h / %b %b %h want zeros", rv_w1, err_w1, rdata_w1, rv_w0, err_w0, rdata_w0); end
    rst_n = 1'b1; #1;
    checks++; if (ready_w1 !== 1'b1 || ready_w0 !== 1'b1) begin fails++;
      $display("FAIL release_ready: got %b/%b want 1/1", ready_w1, ready_w0); end
  endtask

  task automatic test_preload_load;
    logic [31:0] rd; logic er; int lat;
    do_req(1'b0, 1'b1, 32'd0, 32'd0, rd, er, lat);
    do_req(1'b0, 1'b1, 32'd4, 32'd1, rd, er, lat);
    checks++; if (rd !== 32'd0 || er !== 1'b0) begin fails++;
      $display("FAIL store_resp: got rdata %h err %b want 0 0", rd, er); end
    do_req(1'b0, 1'b0, 32'd4, 32'd0, rd, er, lat);
    checks++; if (lat !== 2) begin fails++; $display("FAIL load_latency_w1: got %0d want 2", lat); end
    checks++; if (rd !== 32'd1 || er !== 1'b0) begin fails++;
      $display("FAIL load_addr4: got rdata %h err %b want 1 0", rd, er); end
    do_req(1'b1, 1'b0, 32'd4, 32'd0, rd, er, lat);
    checks++; if (lat !== 1) begin fails++; $display("FAIL load_latency_w0: got %0d want 1", lat); end
  endtask

  task automatic test_store_load;
    logic [31:0] rd; logic er; int lat;
    do_req(1'b0, 1'b1, 32'd40, 32'h37, rd, er, lat);
    do_req(1'b0, 1'b0, 32'd40, 32'd0, rd, er, lat);
    checks++; if (rd !== 32'd55 || er !== 1'b0) begin fails++;
      $display("FAIL load_addr40: got rdata %h err %b want 37 0", rd, er); end
    dbg_addr = 32'd40; #1;
    checks++; if (dbg_w1 !== 32'd55) begin fails++; $display("FAIL dbg_addr40: got %h want 37", dbg_w1); end
    do_req(1'b0, 1'b1, 32'd252, 32'hCAFE_F00D, rd, er, lat);
    do_req(1'b0, 1'b0, 32'd252, 32'd0, rd, er, lat);
    checks++; if (rd !== 32'hCAFE_F00D || er !== 1'b0) begin fails++;
      $display("FAIL load_last_word: got rdata %h err %b want cafef00d 0", rd, er); end
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic er; int lat;
    do_req(1'b0, 1'b0, 32'd6, 32'd0, rd, er, lat);
    checks++; if (rd !== 32'd0 || er !== 1'b1) begin fails++;
      $display("FAIL misaligned_load: got rdata %h err %b want 0 1", rd, er); end
    do_req(1'b0, 1'b0, 32'(4 * DEPTH), 32'd0, rd, er, lat);
    checks++; if (rd !== 32'd0 || er !== 1'b1) begin fails++;
      $display("FAIL range_load: got rdata %h err %b want 0 1", rd, er); end
    do_req(1'b0, 1'b1, 32'd6, 32'hFFFF_FFFF, rd, er, lat);
    checks++; if (er !== 1'b1) begin fails++; $display("FAIL misaligned_store_err: got %b want 1", er); end
    dbg_addr = 32'd4; #1;
    checks++; if (dbg_w1 !== 32'd1) begin fails++; $display("FAIL mem1_unchanged: got %h want 1", dbg_w1); end
    dbg_addr = 32'(4 * DEPTH); #1;
    checks++; if (dbg_w1 !== 32'd0) begin fails++; $display("FAIL dbg_range: got %h want 0", dbg_w1); end
  endtask

  task automatic test_back_to_back;
    int acc [3];
    int k = 0, pulses = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk);
      if (rv_w0) pulses++;
      if (k < 3) begin
        req_we = 1'b1; req_addr = 32'h80 + 32'(4 * k); req_wdata = 32'h1000 + 32'(k);
        valid_w0 = 1'b1;
        if (ready_w0) begin
          acc[k] = cyc;
          model[1][32 + k] = 32'h1000 + 32'(k); known[1][32 + k] = 1'b1;
          k++;
        end
      end else valid_w0 = 1'b0;
    end
    valid_w0 = 1'b0;
    checks++; if (k !== 3) begin fails++; $display("FAIL b2b_accepts: got %0d want 3", k); end
    checks++; if (pulses !== 3) begin fails++; $display("FAIL b2b_pulses: got %0d want 3", pulses); end
    if (k == 3) begin
      checks++; if (acc[1] - acc[0] !== 2 || acc[2] - acc[1] !== 2) begin fails++;
        $display("FAIL b2b_spacing: got %0d,%0d want 2,2", acc[1] - acc[0], acc[2] - acc[1]); end
    end
    for (int i = 0; i < 3; i++) begin
      dbg_addr = 32'h80 + 32'(4 * i); #1;
      checks++; if (dbg_w0 !== 32'h1000 + 32'(i)) begin fails++;
        $display("FAIL b2b_data%0d: got %h want %h", i, dbg_w0, 32'h1000 + 32'(i)); end
    end
  endtask

  task automatic test_random;
    logic [31:0] rd, a, d; logic er; int lat; bit z, we, e;
    for (int n = 0; n < 60; n++) begin
      z  = 1'($urandom);
      we = 1'($urandom);
      d  = $urandom;
      case ($urandom_range(0, 7))
        0:       a = 32'(4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3));
        1:       a = ($urandom | 32'h0000_0100) & 32'hFFFF_FFFC;
        default: a = 32'(4 * $urandom_range(0, DEPTH - 1));
      endcase
      e = exp_err(a);
      do_req(z, we, a, d, rd, er, lat);
      checks++; if (lat !== (z ? 1 : 2)) begin fails++; $display("FAIL rnd_latency: got %0d want %0d", lat, z ? 1 : 2); end
      checks++; if (er !== e) begin fails++; $display("FAIL rnd_err addr %h: got %b want %b", a, er, e); end
      if (we || e) begin
        checks++; if (rd !== 32'd0) begin fails++; $display("FAIL rnd_rdata_zero addr %h: got %h want 0", a, rd); end
      end else if (known[z][a[7:2]]) begin
        checks++; if (rd !== model[z][a[7:2]]) begin fails++;
          $display("FAIL rnd_rdata addr %h: got %h want %h", a, rd, model[z][a[7:2]]); end
      end
      if (!e && known[z][a[7:2]]) begin
        dbg_addr = a; #1;
        checks++; if ((z ? dbg_w0 : dbg_w1) !== model[z][a[7:2]]) begin fails++;
          $display("FAIL rnd_dbg addr %h: got %h want %h", a, z ? dbg_w0 : dbg_w1, model[z][a[7:2]]); end
      end
    end
  endtask

  task automatic test_reset_mid_flight;
    logic [31:0] rd; logic er; int lat;
    do_req(1'b0, 1'b1, 32'd8, 32'h1111_2222, rd, er, lat);
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'd8; req_wdata = 32'h0000_DEAD; valid_w1 = 1'b1;
    @(posedge clk); #1; valid_w1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0; #1;
    checks++; if ({rv_w1, err_w1, rdata_w1, ready_w1} !== 35'd0) begin fails++;
      $display("FAIL rst_in_wait_outputs: got %b %b %h %b want zeros", rv_w1, err_w1, rdata_w1, ready_w1); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (ready_w1 !== 1'b1) begin fails++; $display("FAIL rst_in_wait_ready: got %b want 1", ready_w1); end
    dbg_addr = 32'd8; #1;
    checks++; if (dbg_w1 !== 32'h1111_2222) begin fails++; $display("FAIL store_dropped: got %h want 11112222", dbg_w1); end
    // Reset during RESP: store has committed, pulse must vanish immediately.
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'd12; req_wdata = 32'h0BAD_BEEF; valid_w1 = 1'b1;
    @(posedge clk); #1; valid_w1 = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++; if (rv_w1 !== 1'b1) begin fails++; $display("FAIL resp_before_rst: got %b want 1", rv_w1); end
    rst_n = 1'b0; #1;
    checks++; if (rv_w1 !== 1'b0) begin fails++; $display("FAIL async_clear: got %b want 0", rv_w1); end
    model[0][3] = 32'h0BAD_BEEF; known[0][3] = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    dbg_addr = 32'd12; #1;
    checks++; if (dbg_w1 !== 32'h0BAD_BEEF) begin fails++; $display("FAIL committed_kept: got %h want 0badbeef", dbg_w1); end
  endtask

  task automatic test_fibonacci;
    int fib_exp [12] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89};
    logic [31:0] rd, a, b; logic er; int lat;
    do_req(1'b0, 1'b1, 32'd0, 32'd0, rd, er, lat);
    do_req(1'b0, 1'b1, 32'd4, 32'd1, rd, er, lat);
    for (int i = 2; i < 12; i++) begin
      do_req(1'b0, 1'b0, 32'(4 * (i - 1)), 32'd0, a, er, lat);
      do_req(1'b0, 1'b0, 32'(4 * (i - 2)), 32'd0, b, er, lat);
      do_req(1'b0, 1'b1, 32'(4 * i), a + b, rd, er, lat);
    end
    for (int i = 0; i < 12; i++) begin
      dbg_addr = 32'(4 * i); #1;
      checks++; if (dbg_w1 !== 32'(fib_exp[i])) begin fails++;
        $display("FAIL fib_dump[%0d]: got %0d want %0d", i, dbg_w1, fib_exp[i]); end
    end
  endtask

  initial begin
    for (int z = 0; z < 2; z++) for (int i = 0; i < DEPTH; i++) known[z][i] = 1'b0;
    test_reset;
    test_preload_load;
    test_store_load;
    test_errors;
    test_back_to_back;
    test_random;
    test_reset_mid_flight;
    test_fibonacci;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
